// File: rtl/memory_game_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mg_pkg
// Description : Shared state encoding and default sizes for the memory game
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mg_pkg;

   localparam int DEPTH_DEF = 5;
   localparam int DW_DEF    = 3;
   localparam int AW_DEF    = 3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FILL   = 3'd1,
      ST_SHOW   = 3'd2,
      ST_SELECT = 3'd3,
      ST_GUESS  = 3'd4,
      ST_WIN    = 3'd5,
      ST_LOSE   = 3'd6
   } state_e;

endpackage
`default_nettype wire

// File: rtl/memory_game_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_game_sequencer_if
// Description : Random-source handshake, register-file bus and display stream
//               of the memory game sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface memory_game_sequencer_if #(
   parameter int DW = mg_pkg::DW_DEF,
   parameter int AW = mg_pkg::AW_DEF
);
   logic          rnd_valid_i;
   logic [DW-1:0] rnd_data_i;
   logic          rnd_ready_o;
   logic [AW-1:0] rf_addr_o;
   logic          rf_we_o;
   logic [DW-1:0] rf_wdata_o;
   logic          rf_re_o;
   logic [DW-1:0] rf_rdata_i;
   logic          disp_valid_o;
   logic [AW-1:0] disp_idx_o;
   logic [DW-1:0] disp_digit_o;

   // Sequencer side
   modport master (
      input  rnd_valid_i, rnd_data_i, rf_rdata_i,
      output rnd_ready_o, rf_addr_o, rf_we_o, rf_wdata_o, rf_re_o,
             disp_valid_o, disp_idx_o, disp_digit_o
   );

   // Random source / register file / display side
   modport slave (
      output rnd_valid_i, rnd_data_i, rf_rdata_i,
      input  rnd_ready_o, rf_addr_o, rf_we_o, rf_wdata_o, rf_re_o,
             disp_valid_o, disp_idx_o, disp_digit_o
   );
endinterface
`default_nettype wire

// File: rtl/memory_game_sequencer_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : mg_tick_gen
// Description : Free-running 0..TICK_CYCLES-1 counter with synchronous clear;
//               tick_o is high on the last count of each period.
// Revision    : 1.0 - initial release
// ============================================================================
module mg_tick_gen #(
   parameter int TICK_CYCLES = 100_000_000
) (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic clear_i,
   output logic      tick_o
);
   localparam int            CW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: hold at zero while cleared, wrap after the last count
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || (cnt_q == LAST)) cnt_d = '0;
      else                            cnt_d = cnt_q + CW'(1);
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign tick_o = !clear_i && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/memory_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : memory_game_sequencer
// Description : Game controller: fills the register file from the random
//               source, plays the digits back at the tick rate, then checks
//               player guesses and tracks wrong tries.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_game_sequencer
   import mg_pkg::*;
#(
   parameter int DEPTH       = DEPTH_DEF,
   parameter int DW          = DW_DEF,
   parameter int AW          = AW_DEF,
   parameter int TICK_CYCLES = 100_000_000,
   parameter int MAX_TRIES   = 3
) (
   input  wire logic                 clk,
   input  wire logic                 rst_n,
   input  wire logic                 start_i,
   input  wire logic                 confirm_i,
   input  wire logic                 check_i,
   input  wire logic                 restart_i,
   input  wire logic [7:0]           sw_i,
   memory_game_sequencer_if.master   bus,
   output logic [2:0]                state_o,
   output logic                      err_o,
   output logic                      success_o,
   output logic                      fail_o,
   output logic [1:0]                tries_o
);
   localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
   localparam logic [1:0]    TRIES_MAX = 2'(MAX_TRIES);

   state_e        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] show_idx_q, show_idx_d;
   logic [AW-1:0] sel_addr_q, sel_addr_d;
   logic [AW-1:0] rf_addr_q, rf_addr_d;
   logic          rf_re_q, rf_re_d;
   logic          data_ok_q, data_ok_d;
   logic [1:0]    tries_q, tries_d;
   logic          err_q, err_d;
   logic          success_q, success_d;
   logic          fail_q, fail_d;
   logic          disp_valid_q, disp_valid_d;
   logic [AW-1:0] disp_idx_q, disp_idx_d;

   logic w_xfer;
   logic w_tick;
   logic w_match;

   mg_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (state_q != ST_SHOW),
      .tick_o  (w_tick)
   );

   assign w_xfer  = (state_q == ST_FILL) && bus.rnd_valid_i;
   assign w_match = (sw_i[DW-1:0] == bus.rf_rdata_i);

   // Next-state and next-output computation; restart overrides everything
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      show_idx_d = show_idx_q;
      sel_addr_d = sel_addr_q;
      tries_d    = tries_q;
      data_ok_d  = data_ok_q;
      rf_re_d    = 1'b0;
      rf_addr_d  = '0;
      err_d      = 1'b0;
      if (restart_i) begin
         state_d    = ST_IDLE;
         wr_ptr_d   = '0;
         show_idx_d = '0;
         sel_addr_d = '0;
         tries_d    = '0;
         data_ok_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (start_i) begin
               state_d  = ST_FILL;
               wr_ptr_d = '0;
               tries_d  = '0;
            end
            ST_FILL: if (w_xfer) begin
               if (wr_ptr_q == LAST_IDX) begin
                  // Read of digit 0 is issued so it arrives on the first SHOW cycle
                  state_d    = ST_SHOW;
                  wr_ptr_d   = '0;
                  show_idx_d = '0;
                  rf_re_d    = 1'b1;
               end else begin
                  wr_ptr_d = wr_ptr_q + AW'(1);
               end
            end
            ST_SHOW: begin
               rf_re_d   = 1'b1;
               rf_addr_d = show_idx_q;
               if (w_tick) begin
                  if (show_idx_q == LAST_IDX) begin
                     state_d    = ST_SELECT;
                     show_idx_d = '0;
                     rf_re_d    = 1'b0;
                     rf_addr_d  = '0;
                  end else begin
                     show_idx_d = show_idx_q + AW'(1);
                     rf_addr_d  = show_idx_q + AW'(1);
                  end
               end
            end
            ST_SELECT: if (confirm_i) begin
               if (sw_i < 8'(DEPTH)) begin
                  state_d    = ST_GUESS;
                  sel_addr_d = sw_i[AW-1:0];
                  rf_re_d    = 1'b1;
                  rf_addr_d  = sw_i[AW-1:0];
                  data_ok_d  = 1'b0;
               end else begin
                  err_d = 1'b1;
               end
            end
            ST_GUESS: begin
               rf_re_d   = 1'b1;
               rf_addr_d = sel_addr_q;
               data_ok_d = 1'b1;
               if (check_i && data_ok_q) begin
                  rf_re_d   = 1'b0;
                  rf_addr_d = '0;
                  data_ok_d = 1'b0;
                  if (w_match) begin
                     state_d = ST_WIN;
                  end else begin
                     tries_d = (tries_q == TRIES_MAX) ? tries_q : tries_q + 2'd1;
                     if (tries_q + 2'd1 == TRIES_MAX) state_d = ST_LOSE;
                     else                             state_d = ST_SELECT;
                  end
               end
            end
            default: ;
         endcase
      end
      success_d    = (state_d == ST_WIN);
      fail_d       = (state_d == ST_LOSE);
      // Display the digit whose read was issued this cycle; never on the exit edge
      disp_valid_d = (state_q == ST_SHOW) && (state_d == ST_SHOW);
      disp_idx_d   = disp_valid_d ? rf_addr_q : '0;
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         wr_ptr_q     <= '0;
         show_idx_q   <= '0;
         sel_addr_q   <= '0;
         rf_addr_q    <= '0;
         rf_re_q      <= 1'b0;
         data_ok_q    <= 1'b0;
         tries_q      <= '0;
         err_q        <= 1'b0;
         success_q    <= 1'b0;
         fail_q       <= 1'b0;
         disp_valid_q <= 1'b0;
         disp_idx_q   <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         show_idx_q   <= show_idx_d;
         sel_addr_q   <= sel_addr_d;
         rf_addr_q    <= rf_addr_d;
         rf_re_q      <= rf_re_d;
         data_ok_q    <= data_ok_d;
         tries_q      <= tries_d;
         err_q        <= err_d;
         success_q    <= success_d;
         fail_q       <= fail_d;
         disp_valid_q <= disp_valid_d;
         disp_idx_q   <= disp_idx_d;
      end
   end

   // FILL drives the write port straight from state and write pointer
   assign bus.rnd_ready_o  = (state_q == ST_FILL);
   assign bus.rf_we_o      = w_xfer;
   assign bus.rf_wdata_o   = w_xfer ? bus.rnd_data_i : '0;
   assign bus.rf_addr_o    = (state_q == ST_FILL) ? wr_ptr_q : rf_addr_q;
   assign bus.rf_re_o      = rf_re_q;
   assign bus.disp_valid_o = disp_valid_q;
   assign bus.disp_idx_o   = disp_idx_q;
   // The register file output register supplies the digit aligned with disp_idx
   assign bus.disp_digit_o = disp_valid_q ? bus.rf_rdata_i : '0;

   assign state_o   = state_q;
   assign err_o     = err_q;
   assign success_o = success_q;
   assign fail_o    = fail_q;
   assign tries_o   = tries_q;

endmodule
`default_nettype wire
